// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and iteration count.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 5;

  function automatic logic op_is_div(input mdu_op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_e o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/mdu_negate64.sv
// Conditional two's-complement negation; used for operand magnitudes and
// for the sign fix-up of the final product, quotient and remainder.
module mdu_negate64 #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = din;
    if (neg) dout = ~din + W'(1);
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply (shift-add) and restoring divide; result is
// {HI,LO} and is registered only on the cycle done is raised.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        div_by_zero
);

  mdu_state_e       state, state_nx;
  mdu_op_e          op_in, op_q;
  logic             sign_a_q, sign_b_q;
  logic [31:0]      hi_q, lo_q, bop_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      result_q;
  logic             dbz_q;

  logic             in_signed, div_zero, last_iter;
  logic [31:0]      abs_a, abs_b;
  logic [32:0]      mul_sum, trial;
  logic [31:0]      step_hi, step_lo;
  logic             neg_q, neg_r;
  logic [63:0]      prod_fix, final_res;
  logic [31:0]      quot_fix, rem_fix;

  assign op_in     = mdu_op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign div_zero  = op_is_div(op_in) && (b == '0);
  assign last_iter = (cnt_q == CNT_W'(ITER - 1));

  mdu_negate64 #(.W(32)) u_abs_a (.din(a), .neg(in_signed & a[31]), .dout(abs_a));
  mdu_negate64 #(.W(32)) u_abs_b (.din(b), .neg(in_signed & b[31]), .dout(abs_b));

  // hi_q/lo_q double as {acc, multiplier} for mult and {rem, dividend/quot} for div
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bop_q} : 33'd0);
    trial   = {hi_q, lo_q[31]} - {1'b0, bop_q};
    if (op_is_div(op_q)) begin
      step_hi = trial[32] ? {hi_q[30:0], lo_q[31]} : trial[31:0];
      step_lo = {lo_q[30:0], ~trial[32]};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], lo_q[31:1]};
    end
  end

  assign neg_q = sign_a_q ^ sign_b_q;
  assign neg_r = sign_a_q;

  mdu_negate64 #(.W(64)) u_fix_prod (.din({step_hi, step_lo}), .neg(neg_q), .dout(prod_fix));
  mdu_negate64 #(.W(32)) u_fix_quot (.din(step_lo), .neg(neg_q), .dout(quot_fix));
  mdu_negate64 #(.W(32)) u_fix_rem  (.din(step_hi), .neg(neg_r), .dout(rem_fix));

  assign final_res = op_is_div(op_q) ? {rem_fix, quot_fix} : prod_fix;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cancel) begin
      state_nx = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (start) state_nx = div_zero ? ST_DONE : ST_RUN;
        ST_RUN:  if (last_iter) state_nx = ST_DONE;
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= OP_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      bop_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else if (!cancel) begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= op_in;
            sign_a_q <= in_signed & a[31];
            sign_b_q <= in_signed & b[31];
            hi_q     <= '0;
            lo_q     <= abs_a;
            bop_q    <= abs_b;
            cnt_q    <= '0;
            dbz_q    <= div_zero;
            if (div_zero) result_q <= {a, 32'hFFFF_FFFF};
          end
        end
        ST_RUN: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          if (last_iter) result_q <= final_res;
          else           cnt_q    <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state == ST_RUN);
  assign done        = (state == ST_DONE);
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy, done, div_by_zero;
  logic [63:0] result;

  int n_chk = 0;
  int n_bad = 0;

  mult_div_unit u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives start in cycle T; returns at the sampling point of cycle T+1.
  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc = offset from T of the cycle where done is seen (60 = timed out).
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 1; busy_cnt = 0;
    while (!done && cyc < 60) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [63:0] exp_res,
                       input int exp_cyc, input int exp_busy, input logic exp_dbz);
    int cyc, bc;
    logic [63:0] held;
    start_op(o, x, y);
    wait_done(cyc, bc);
    chk({tag, ".done_cyc"}, 64'(cyc), 64'(exp_cyc));
    chk({tag, ".busy_cnt"}, 64'(bc), 64'(exp_busy));
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    held = result;
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk({tag, ".hold"}, result, exp_res);
    chk({tag, ".hold_reg"}, result, held);
  endtask

  initial begin
    int n_done;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;

    repeat (3) @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.dbz", 64'(div_by_zero), 64'd0);
    chk("rst.result", result, 64'd0);
    rst_n = 1'b1;

    do_op("mult_neg1x2", 2'b00, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE, 33, 32, 1'b0);
    do_op("multu_max_x2", 2'b01, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 33, 32, 1'b0);
    do_op("mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'h5, 64'hFFFF_FFFF_FFFF_FFF1, 33, 32, 1'b0);
    do_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 33, 32, 1'b0);
    do_op("divu_7_2", 2'b11, 32'h7, 32'h2, 64'h0000_0001_0000_0003, 33, 32, 1'b0);
    do_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, 32, 1'b0);
    do_op("divu_by0", 2'b11, 32'h1234, 32'h0, 64'h0000_1234_FFFF_FFFF, 1, 0, 1'b1);

    // start at T, ignored start at T+5, cancel at T+10
    start_op(2'b01, 32'h10, 32'h10);
    chk("cancel.dbz_cleared", 64'(div_by_zero), 64'd0);
    chk("cancel.busy_t1", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h3; b = 32'h3;
    @(negedge clk);
    start = 1'b0;
    chk("cancel.busy_t6", 64'(busy), 64'd1);
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel.busy_t11", 64'(busy), 64'd0);
    chk("cancel.done_t11", 64'(done), 64'd0);
    chk("cancel.result", result, 64'h0000_1234_FFFF_FFFF);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    chk("cancel.no_activity", 64'(n_done), 64'd0);

    // cancel and start together: cancel wins
    start = 1'b1; cancel = 1'b1; op = 2'b01; a = 32'h2; b = 32'h2;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("cancel_start.busy", 64'(busy), 64'd0);
    chk("cancel_start.done", 64'(done), 64'd0);

    // reset at T+20 of a signed divide, then mult 3*5 right after release
    start_op(2'b10, 32'h0000_0064, 32'h7);
    repeat (19) @(negedge clk);
    chk("rst_mid.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid.busy", 64'(busy), 64'd0);
    chk("rst_mid.done", 64'(done), 64'd0);
    chk("rst_mid.dbz", 64'(div_by_zero), 64'd0);
    chk("rst_mid.result", result, 64'd0);
    rst_n = 1'b1; start = 1'b1; op = 2'b00; a = 32'h3; b = 32'h5;
    @(negedge clk);
    start = 1'b0;
    begin
      int cyc, bc;
      wait_done(cyc, bc);
      chk("post_rst.done_cyc", 64'(cyc), 64'd33);
      chk("post_rst.busy_cnt", 64'(bc), 64'd32);
      chk("post_rst.result", result, 64'h0000_0000_0000_000F);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
